// File: rtl/cpu_run_control_pkg.sv
// Shared definitions for the CPU run/halt/step controller.
package cpu_run_control_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    DRAIN = 2'd3
  } run_state_t;

  // Micro-step counter value that marks an instruction boundary.
  localparam logic [1:0] STEP_BOUNDARY = 2'd0;

endpackage

// File: rtl/cpu_run_control_button_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge press pulse
// for one raw front-panel button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock_input,
  input  logic reset_n,
  input  logic button,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] count;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock_input or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], button};
    end
  end

  // Accept a new level only after enough consecutive differing samples;
  // the counter restarts on any agreeing sample so it can never overflow.
  always_ff @(posedge clock_input or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync[1] == level) begin
        count <= '0;
      end else if (count == LAST_COUNT) begin
        count <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_control.sv
// Run/halt/single-step controller: divides the clock into ticks and
// issues one-clock cpu_enable pulses according to the front-panel state.
module cpu_run_control
  import cpu_run_control_pkg::*;
#(
  parameter int DIV_WIDTH       = 18,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int START_RUNNING   = 0
) (
  input  logic        clock_input,
  input  logic        reset_n,
  input  logic        run_button,
  input  logic        step_button,
  input  logic [1:0]  step,
  input  logic [15:0] pc,
  input  logic [15:0] break_addr,
  input  logic        break_enable,
  output logic        cpu_enable,
  output logic        halted,
  output logic        break_hit,
  output logic [1:0]  state
);

  localparam run_state_t RESET_STATE = (START_RUNNING != 0) ? RUN : HALT;

  run_state_t           state_q;
  logic [DIV_WIDTH-1:0] prescaler;
  logic                 tick;
  logic                 run_press;
  logic                 step_press;
  logic                 first_tick;
  logic                 break_match;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_debounce (
    .clock_input (clock_input),
    .reset_n     (reset_n),
    .button      (run_button),
    .press       (run_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_debounce (
    .clock_input (clock_input),
    .reset_n     (reset_n),
    .button      (step_button),
    .press       (step_press)
  );

  assign tick        = &prescaler;
  assign break_match = break_enable && (step == STEP_BOUNDARY) && (pc == break_addr);
  assign halted      = (state_q == HALT);
  assign state       = state_q;

  // Free-running prescaler; wraps naturally after the all-ones tick cycle.
  always_ff @(posedge clock_input or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + DIV_WIDTH'(1);
    end
  end

  // Run-control FSM; first_tick marks the first tick after a state entry,
  // which skips the breakpoint in RUN and forces a pulse in STEP/DRAIN.
  always_ff @(posedge clock_input or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      cpu_enable <= 1'b0;
      break_hit  <= 1'b0;
      first_tick <= 1'b1;
    end else begin
      cpu_enable <= 1'b0;
      case (state_q)
        HALT: begin
          if (run_press) begin
            state_q    <= RUN;
            break_hit  <= 1'b0;
            first_tick <= 1'b1;
          end else if (step_press) begin
            state_q    <= STEP;
            break_hit  <= 1'b0;
            first_tick <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            first_tick <= 1'b0;
            if (!first_tick && break_match) begin
              state_q   <= HALT;
              break_hit <= 1'b1;
            end else begin
              cpu_enable <= 1'b1;
              if (run_press) begin
                state_q    <= DRAIN;
                first_tick <= 1'b1;
              end
            end
          end else if (run_press) begin
            state_q    <= DRAIN;
            first_tick <= 1'b1;
          end
        end
        STEP, DRAIN: begin
          if (tick) begin
            if (first_tick) begin
              cpu_enable <= 1'b1;
              first_tick <= 1'b0;
            end else if (step != STEP_BOUNDARY) begin
              cpu_enable <= 1'b1;
            end else begin
              state_q <= HALT;
            end
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_control.sv
// Self-checking bench for cpu_run_control with a tick every 4 clocks and
// a 3-sample debounce; a small CPU model advances step/pc on each pulse.
module tb_cpu_run_control;

  logic        clock_input = 1'b0;
  logic        reset_n = 1'b0;
  logic        run_button = 1'b0;
  logic        step_button = 1'b0;
  logic [1:0]  step = 2'd0;
  logic [15:0] pc = 16'd0;
  logic [15:0] break_addr = 16'd0;
  logic        break_enable = 1'b0;
  logic        cpu_enable;
  logic        halted;
  logic        break_hit;
  logic [1:0]  state;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle_count = 0;
  int pulse_count = 0;
  int last_pulse = -1;
  int gap_errors = 0;

  typedef struct {
    string      name;
    logic       press_run;
    logic       press_step;
    int         hold;
    int         window;
    int         exp_pulses;
    logic [1:0] exp_state;
    logic       exp_break;
  } vector_t;

  vector_t vectors [5];

  cpu_run_control #(
    .DIV_WIDTH       (2),
    .DEBOUNCE_CYCLES (3),
    .START_RUNNING   (0)
  ) dut (
    .clock_input  (clock_input),
    .reset_n      (reset_n),
    .run_button   (run_button),
    .step_button  (step_button),
    .step         (step),
    .pc           (pc),
    .break_addr   (break_addr),
    .break_enable (break_enable),
    .cpu_enable   (cpu_enable),
    .halted       (halted),
    .break_hit    (break_hit),
    .state        (state)
  );

  // Free-running bench clock.
  always #5 clock_input = ~clock_input;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock; sample just after the edge and let the CPU model react to a pulse.
  task automatic advanceCycle();
    @(posedge clock_input);
    #1;
    cycle_count++;
    if (cpu_enable) begin
      pulse_count++;
      if (last_pulse >= 0 && (cycle_count - last_pulse) != 4) gap_errors++;
      last_pulse = cycle_count;
      step = step + 2'd1;
      if (step == 2'd0) pc = pc + 16'd1;
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    int start_pulses;
    start_pulses = pulse_count;
    last_pulse   = -1;
    gap_errors   = 0;
    run_button   = v.press_run;
    step_button  = v.press_step;
    repeat (v.hold) advanceCycle();
    run_button  = 1'b0;
    step_button = 1'b0;
    repeat (v.window) advanceCycle();
    if (v.exp_pulses >= 0)
      checkOutput({v.name, "_pulses"}, pulse_count - start_pulses, v.exp_pulses);
    checkOutput({v.name, "_state"}, int'(state), int'(v.exp_state));
    checkOutput({v.name, "_halted"}, int'(halted), (v.exp_state == 2'd0) ? 1 : 0);
    checkOutput({v.name, "_break_hit"}, int'(break_hit), int'(v.exp_break));
    checkOutput({v.name, "_pulse_gap_errors"}, gap_errors, 0);
    if (v.exp_state == 2'd0)
      checkOutput({v.name, "_step_at_boundary"}, int'(step), 0);
  endtask

  initial begin
    int guard;
    int p0;

    vectors[0] = '{"step_single",  1'b0, 1'b1, 10, 30,  4, 2'd0, 1'b0};
    vectors[1] = '{"step_glitch",  1'b0, 1'b1,  2, 20,  0, 2'd0, 1'b0};
    vectors[2] = '{"step_long",    1'b0, 1'b1, 15, 30,  4, 2'd0, 1'b0};
    vectors[3] = '{"both_to_run",  1'b1, 1'b1, 10, 20, -1, 2'd1, 1'b0};
    vectors[4] = '{"run_to_drain", 1'b1, 1'b0, 10, 40, -1, 2'd0, 1'b0};

    #2;
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_halted", int'(halted), 1);
    checkOutput("reset_cpu_enable", int'(cpu_enable), 0);
    checkOutput("reset_break_hit", int'(break_hit), 0);
    repeat (3) @(posedge clock_input);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 5; i++) applyStimulus(vectors[i]);

    // Breakpoint: two instructions from 0x000E reach 0x0010 at step 0.
    break_enable = 1'b1;
    break_addr   = 16'h0010;
    pc           = 16'h000E;
    step         = 2'd0;
    p0 = pulse_count; last_pulse = -1; gap_errors = 0;
    run_button = 1'b1;
    repeat (10) advanceCycle();
    run_button = 1'b0;
    guard = 0;
    while (!halted && guard < 100) begin advanceCycle(); guard++; end
    checkOutput("bp_no_timeout", (guard < 100) ? 1 : 0, 1);
    checkOutput("bp_pulses", pulse_count - p0, 8);
    checkOutput("bp_state", int'(state), 0);
    checkOutput("bp_break_hit", int'(break_hit), 1);
    checkOutput("bp_pc", int'(pc), 16'h0010);
    checkOutput("bp_gap_errors", gap_errors, 0);

    // Resume from the breakpoint; the button stays held to prove one press.
    p0 = pulse_count; last_pulse = -1; gap_errors = 0;
    run_button = 1'b1;
    guard = 0;
    while (halted && guard < 20) begin advanceCycle(); guard++; end
    checkOutput("resume_leaves_halt", int'(halted), 0);
    checkOutput("resume_clears_break", int'(break_hit), 0);
    guard = 0;
    while (pulse_count == p0 && guard < 10) begin advanceCycle(); guard++; end
    checkOutput("resume_first_pulse", pulse_count - p0, 1);
    checkOutput("resume_pc_at_break", int'(pc), 16'h0010);
    checkOutput("resume_state_run", int'(state), 1);
    p0 = pulse_count;
    repeat (40) advanceCycle();
    checkOutput("run_pulse_rate", pulse_count - p0, 10);
    checkOutput("run_held_button_state", int'(state), 1);
    checkOutput("run_break_hit", int'(break_hit), 0);
    checkOutput("run_gap_errors", gap_errors, 0);
    run_button = 1'b0;
    repeat (10) advanceCycle();
    checkOutput("run_after_release", int'(state), 1);

    // Drain requested mid-instruction finishes at the next boundary.
    guard = 0;
    while (step != 2'd2 && guard < 20) begin advanceCycle(); guard++; end
    checkOutput("drain_reach_step2", int'(step), 2);
    last_pulse = -1; gap_errors = 0;
    run_button = 1'b1;
    repeat (10) advanceCycle();
    run_button = 1'b0;
    guard = 0;
    while (!halted && guard < 100) begin advanceCycle(); guard++; end
    checkOutput("drain_no_timeout", (guard < 100) ? 1 : 0, 1);
    checkOutput("drain_state", int'(state), 0);
    checkOutput("drain_step_boundary", int'(step), 0);
    checkOutput("drain_gap_errors", gap_errors, 0);
    p0 = pulse_count;
    repeat (12) advanceCycle();
    checkOutput("drain_no_pulse_in_halt", pulse_count - p0, 0);

    // Asynchronous reset right after a STEP pulse.
    break_enable = 1'b0;
    p0 = pulse_count;
    step_button = 1'b1;
    guard = 0;
    while (pulse_count == p0 && guard < 30) begin advanceCycle(); guard++; end
    checkOutput("rst_step_pulse_seen", pulse_count - p0, 1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_async_cpu_enable", int'(cpu_enable), 0);
    checkOutput("rst_async_state", int'(state), 0);
    checkOutput("rst_async_halted", int'(halted), 1);
    step_button = 1'b0;
    repeat (3) advanceCycle();
    reset_n = 1'b1;
    step = 2'd0;
    p0 = pulse_count;
    repeat (30) advanceCycle();
    checkOutput("rst_no_pulse_after", pulse_count - p0, 0);
    checkOutput("rst_stays_halted", int'(state), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
